// File: rtl/cruise_pkg.sv
// Shared cruise-control definitions: one-hot state codes, default speed limits
// and a saturation helper; also consumed by the downstream code-ROM stage.
package cruise_pkg;

  typedef logic [4:0] state_t;

  localparam state_t ST_OFF     = 5'b00001;
  localparam state_t ST_READY   = 5'b00010;
  localparam state_t ST_CRUISE  = 5'b00100;
  localparam state_t ST_ACCEL   = 5'b01000;
  localparam state_t ST_SUSPEND = 5'b10000;

  localparam int DEF_MIN_SPEED    = 40;
  localparam int DEF_MAX_SPEED    = 200;
  localparam int DEF_SUSP_TIMEOUT = 1000;

  function automatic logic [7:0] sat_max(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/cruise_ctrl_fsm_rise_detect.sv
// One-bit rising-edge detector; the armed flag suppresses an edge for a level
// already high when reset releases.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= d_i;
      armed_q <= 1'b1;
    end
  end

  assign rise_o = armed_q & d_i & ~prev_q;

endmodule

// File: rtl/cruise_ctrl_fsm.sv
// Cruise-control supervisor: one-hot FSM with set-speed capture, saturation,
// suspend timeout and a registered speed error; all outputs registered.
module cruise_ctrl_fsm
  import cruise_pkg::*;
#(
  parameter int MIN_SPEED    = DEF_MIN_SPEED,
  parameter int MAX_SPEED    = DEF_MAX_SPEED,
  parameter int SUSP_TIMEOUT = DEF_SUSP_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              on_btn,
  input  logic              set_btn,
  input  logic              resume_btn,
  input  logic              brake,
  input  logic              accel_pedal,
  input  logic [7:0]        speed,
  output logic [4:0]        state_oh,
  output logic [7:0]        set_speed,
  output logic signed [8:0] speed_err
);

  localparam int              CNT_W    = $clog2(SUSP_TIMEOUT) + 1;
  localparam logic [7:0]      MIN_S    = 8'(MIN_SPEED);
  localparam logic [7:0]      MAX_S    = 8'(MAX_SPEED);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SUSP_TIMEOUT - 1);

  logic on_rise, set_rise, res_rise;

  rise_detect u_on_rd  (.clk(clk), .rst_n(rst_n), .d_i(on_btn),     .rise_o(on_rise));
  rise_detect u_set_rd (.clk(clk), .rst_n(rst_n), .d_i(set_btn),    .rise_o(set_rise));
  rise_detect u_res_rd (.clk(clk), .rst_n(rst_n), .d_i(resume_btn), .rise_o(res_rise));

  state_t            state_q, state_d;
  logic [7:0]        set_q, set_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic signed [8:0] err_q, err_d;
  logic              speed_ok;

  assign speed_ok = (speed >= MIN_S);

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    cnt_d   = '0;
    if (on_rise && (state_q != ST_OFF)) begin
      state_d = ST_OFF;
      set_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: if (on_rise) state_d = ST_READY;
        ST_READY:
          if (set_rise && !brake && speed_ok && (speed <= MAX_S)) begin
            state_d = ST_CRUISE;
            set_d   = speed;
          end
        ST_CRUISE:
          if (brake || !speed_ok)  state_d = ST_SUSPEND;
          else if (accel_pedal)    state_d = ST_ACCEL;
          else if (set_rise)       set_d = (set_q >= MAX_S) ? MAX_S : set_q + 8'd1;
        ST_ACCEL:
          if (brake) state_d = ST_SUSPEND;
          else if (!accel_pedal) begin
            state_d = ST_CRUISE;
            set_d   = sat_max((set_q > speed) ? set_q : speed, MAX_S);
          end
        ST_SUSPEND:
          // resume takes precedence over the timeout expiring in the same cycle
          if (res_rise && !brake && speed_ok) begin
            state_d = ST_CRUISE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_READY;
            set_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        default: begin
          state_d = ST_OFF;
          set_d   = '0;
        end
      endcase
    end
  end

  // error reflects the set speed being registered alongside it
  assign err_d = (state_d == ST_CRUISE) ?
                 $signed({1'b0, set_d}) - $signed({1'b0, speed}) : 9'sd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      set_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign state_oh  = state_q;
  assign set_speed = set_q;
  assign speed_err = err_q;

endmodule
